// File: rtl/bypass_scoreboard.sv
// Operand bypass scoreboard: tracks DEPTH in-flight producers, forwards their
// results to RD_PORTS operand readers, raises stall on unready data and retires the oldest entry.
module bypass_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int CH_W     = 4,
  parameter int DEPTH    = 3,
  parameter int RD_PORTS = 2,
  parameter int EXCL_CH  = 14
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         adv,
  input  logic                         iss_valid,
  input  logic [CH_W-1:0]              iss_ch,
  input  logic                         iss_hi,
  input  logic                         iss_rdy,
  input  logic [DATA_W-1:0]            iss_data,
  input  logic                         fill_valid,
  input  logic [$clog2(DEPTH)-1:0]     fill_stage,
  input  logic [DATA_W-1:0]            fill_data,
  input  logic [RD_PORTS-1:0]          rd_en,
  input  logic [RD_PORTS*CH_W-1:0]     rd_ch,
  input  logic [RD_PORTS*DATA_W-1:0]   rd_reg,
  output logic [RD_PORTS*DATA_W-1:0]   rd_data,
  input  logic                         excl_en,
  output logic                         stall,
  output logic                         wb_valid,
  output logic [CH_W-1:0]              wb_ch,
  output logic                         wb_hi,
  output logic [DATA_W-1:0]            wb_data,
  output logic                         err,
  output logic [15:0]                  stall_cnt
);

  localparam int HW = DATA_W / 2;

  logic              r_valid [DEPTH];
  logic [CH_W-1:0]   r_ch    [DEPTH];
  logic              r_hi    [DEPTH];
  logic              r_rdy   [DEPTH];
  logic [DATA_W-1:0] r_data  [DEPTH];

  logic              r_wb_valid;
  logic [CH_W-1:0]   r_wb_ch;
  logic              r_wb_hi;
  logic [DATA_W-1:0] r_wb_data;
  logic              r_err;
  logic [15:0]       r_stall_cnt;

  // Entry view with any same-cycle fill already merged in.
  logic              w_rdy    [DEPTH];
  logic [DATA_W-1:0] w_data   [DEPTH];
  logic              w_fwd_ok [DEPTH];
  logic [RD_PORTS*DATA_W-1:0] w_rd_data;
  logic              w_stall;

  always_comb begin
    for (int s = 0; s < DEPTH; s++) begin
      w_rdy[s]    = r_rdy[s];
      w_data[s]   = r_data[s];
      if (fill_valid && r_valid[s] && (int'(fill_stage) == s)) begin
        w_rdy[s]  = 1'b1;
        w_data[s] = fill_data;
      end
      w_fwd_ok[s] = r_valid[s] && !(excl_en && (r_ch[s] == CH_W'(EXCL_CH)));
    end
  end

  // Youngest match wins; an upper-half producer takes its low half from the
  // next older full-width producer of the same channel, else the register file.
  always_comb begin
    w_rd_data = '0;
    w_stall   = 1'b0;
    for (int p = 0; p < RD_PORTS; p++) begin
      logic [CH_W-1:0]   ch;
      logic [DATA_W-1:0] reg_v;
      logic [DATA_W-1:0] out_v;
      logic              hit, hit_hi, hit_rdy, lo_hit, lo_rdy, st;
      logic [DATA_W-1:0] hit_data, lo_data;
      ch       = rd_ch[p*CH_W +: CH_W];
      reg_v    = rd_reg[p*DATA_W +: DATA_W];
      hit      = 1'b0;
      hit_hi   = 1'b0;
      hit_rdy  = 1'b0;
      hit_data = '0;
      lo_hit   = 1'b0;
      lo_rdy   = 1'b0;
      lo_data  = '0;
      for (int s = 0; s < DEPTH; s++) begin
        if (!hit && w_fwd_ok[s] && (r_ch[s] == ch)) begin
          hit      = 1'b1;
          hit_hi   = r_hi[s];
          hit_rdy  = w_rdy[s];
          hit_data = w_data[s];
        end else if (hit && hit_hi && !lo_hit && w_fwd_ok[s] && (r_ch[s] == ch) && !r_hi[s]) begin
          lo_hit  = 1'b1;
          lo_rdy  = w_rdy[s];
          lo_data = w_data[s];
        end
      end
      out_v = reg_v;
      st    = 1'b0;
      if (rd_en[p] && (ch != '0) && hit) begin
        if (!hit_hi) begin
          out_v = hit_data;
          st    = !hit_rdy;
        end else begin
          out_v[DATA_W-1:HW] = hit_data[DATA_W-1:HW];
          st                 = !hit_rdy;
          if (lo_hit) begin
            out_v[HW-1:0] = lo_data[HW-1:0];
            st            = st || !lo_rdy;
          end
        end
      end
      w_rd_data[p*DATA_W +: DATA_W] = out_v;
      w_stall = w_stall || st;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < DEPTH; s++) r_valid[s] <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_wb_ch     <= '0;
      r_wb_hi     <= 1'b0;
      r_wb_data   <= '0;
      r_err       <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
      r_wb_valid <= 1'b0;
      if (flush) begin
        for (int s = 0; s < DEPTH; s++) r_valid[s] <= 1'b0;
      end else if (adv) begin
        if (r_valid[DEPTH-1]) begin
          if (w_rdy[DEPTH-1]) begin
            r_wb_valid <= 1'b1;
            r_wb_ch    <= r_ch[DEPTH-1];
            r_wb_hi    <= r_hi[DEPTH-1];
            r_wb_data  <= w_data[DEPTH-1];
          end else begin
            r_err <= 1'b1;
          end
        end
        for (int s = DEPTH-1; s > 0; s--) begin
          r_valid[s] <= r_valid[s-1];
          r_ch[s]    <= r_ch[s-1];
          r_hi[s]    <= r_hi[s-1];
          r_rdy[s]   <= w_rdy[s-1];
          r_data[s]  <= w_data[s-1];
        end
        r_valid[0] <= iss_valid && (iss_ch != '0);
        r_ch[0]    <= iss_ch;
        r_hi[0]    <= iss_hi;
        r_rdy[0]   <= iss_rdy;
        r_data[0]  <= iss_data;
      end else begin
        for (int s = 0; s < DEPTH; s++) begin
          r_rdy[s]  <= w_rdy[s];
          r_data[s] <= w_data[s];
        end
      end
    end
  end

  assign rd_data   = w_rd_data;
  assign stall     = w_stall;
  assign wb_valid  = r_wb_valid;
  assign wb_ch     = r_wb_ch;
  assign wb_hi     = r_wb_hi;
  assign wb_data   = r_wb_data;
  assign err       = r_err;
  assign stall_cnt = r_stall_cnt;

endmodule
